breath_led_multi: RTL

//  Multi-channel breathing-LED PWM generator for the alarm front panel.
//  One shared prescaler, PWM counter and triangle phase drive CH outputs.

---
 rtl/breath_led_multi.sv | 138 +++++++++++++
 1 files changed

// File: rtl/breath_led_multi.sv
// rtl/breath_led_multi.sv - multi-channel breathing-LED PWM with shared prescaler/phase
// Optional quadratic brightness curve: define BREATH_LED_GAMMA_EN.
module breath_led_multi #(
  parameter int CLK_DIV   = 50,
  parameter int PWM_STEPS = 1000,
  parameter int CH        = 4,
  parameter int PHASE_OFS = 250
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   pwm,
  output logic            period_tick,
  output logic            breath_done
);
  localparam int PW = $clog2(2*PWM_STEPS);
  localparam int SW = $clog2(PWM_STEPS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] CNT_LAST = SW'(PWM_STEPS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*PWM_STEPS - 1);
  localparam logic [PW:0]   PH_MOD   = (PW+1)'(2*PWM_STEPS);
  localparam logic [PW:0]   HALF     = (PW+1)'(PWM_STEPS);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          period_tick_q, period_tick_d;
  logic          breath_done_q, breath_done_d;
  logic          tick, pend, ph_wrap;
  logic [PW-1:0] phase_next;

  always_comb begin
    tick       = (div_cnt_q == DIV_LAST);
    pend       = tick && (pwm_cnt_q == CNT_LAST);
    ph_wrap    = pend && (phase_q == PH_LAST);
    phase_next = phase_q;
    if (pend) begin
      phase_next = ph_wrap ? '0 : phase_q + PW'(1);
    end

    div_cnt_d     = tick ? '0 : div_cnt_q + DW'(1);
    pwm_cnt_d     = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + SW'(1);
    end
    phase_d       = phase_next;
    period_tick_d = pend;
    breath_done_d = ph_wrap;

    // en low behaves like a synchronous reset of the whole engine
    if (!en) begin
      div_cnt_d     = '0;
      pwm_cnt_d     = '0;
      phase_d       = '0;
      period_tick_d = 1'b0;
      breath_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      phase_q       <= '0;
      period_tick_q <= 1'b0;
      breath_done_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      phase_q       <= phase_d;
      period_tick_q <= period_tick_d;
      breath_done_q <= breath_done_d;
    end
  end

  assign period_tick = period_tick_q;
  assign breath_done = breath_done_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    // Offset reduced at elaboration so the runtime sum fits in PW+1 bits
    localparam int OFS = (k * PHASE_OFS) % (2*PWM_STEPS);

    logic [PW:0]   p_sum, p_k;
    logic [SW-1:0] tri_k, curve_k;
    logic [SW-1:0] duty_q, duty_d;
    logic [1:0]    mode_q, mode_d;
    logic          pwm_q, pwm_d, below;

`ifdef BREATH_LED_GAMMA_EN
    logic [2*SW-1:0] sq_k;
    assign sq_k    = (2*SW)'(tri_k) * (2*SW)'(tri_k);
    assign curve_k = SW'(sq_k >> SW);
`else
    assign curve_k = tri_k;
`endif

    always_comb begin
      p_sum = {1'b0, phase_next} + (PW+1)'(OFS);
      p_k   = (p_sum >= PH_MOD) ? p_sum - PH_MOD : p_sum;
      tri_k = (p_k < HALF) ? SW'(p_k) : SW'(PH_MOD - (PW+1)'(1) - p_k);

      duty_d = pend ? curve_k : duty_q;
      mode_d = pend ? mode[2*k +: 2] : mode_q;

      below = (pwm_cnt_q < duty_q);
      case (mode_q)
        2'b00:   pwm_d = 1'b0;
        2'b01:   pwm_d = 1'b1;
        2'b10:   pwm_d = below;
        default: pwm_d = !below;
      endcase

      if (!en) begin
        duty_d = '0;
        mode_d = 2'b00;
        pwm_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q <= '0;
        mode_q <= 2'b00;
        pwm_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        mode_q <= mode_d;
        pwm_q  <= pwm_d;
      end
    end

    assign pwm[k] = pwm_q;
  end

endmodule
